// File: rtl/uart_cmd_loader.sv
// Command sequencer between the UART byte stream and the core: decodes
// single-byte commands and assembles LOAD payloads into imem word writes.
module uart_cmd_loader #(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 300000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_run,
  output logic              cpu_step,
  output logic              cpu_rst,
  output logic              busy,
  output logic              err,
  output logic [1:0]        state_dbg
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;
  localparam logic [7:0] CMD_STEP = 8'h03;
  localparam logic [7:0] CMD_RST  = 8'h04;
  localparam logic [7:0] CMD_HALT = 8'h05;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEN   = 2'd1,
    DATA  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t              state,     state_nxt;
  logic [7:0]          word_cnt,  word_cnt_nxt;
  logic [ADDR_W-1:0]   addr,      addr_nxt;
  logic [1:0]          byte_idx,  byte_idx_nxt;
  logic [WORD_W-1:0]   asm_word,  asm_word_nxt;
  logic [TMO_W-1:0]    tmo_cnt,   tmo_cnt_nxt;
  logic                run_q,     run_nxt;
  logic                step_q,    step_nxt;
  logic                rst_q,     rst_nxt;
  logic                err_q,     err_nxt;
  logic                in_load;
  logic                timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      word_cnt <= '0;
      addr     <= '0;
      byte_idx <= '0;
      asm_word <= '0;
      tmo_cnt  <= '0;
      run_q    <= 1'b0;
      step_q   <= 1'b0;
      rst_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      word_cnt <= word_cnt_nxt;
      addr     <= addr_nxt;
      byte_idx <= byte_idx_nxt;
      asm_word <= asm_word_nxt;
      tmo_cnt  <= tmo_cnt_nxt;
      run_q    <= run_nxt;
      step_q   <= step_nxt;
      rst_q    <= rst_nxt;
      err_q    <= err_nxt;
    end
  end

  // Idle counter only runs while waiting for payload bytes; WRITE and IDLE hold it at zero.
  assign in_load = (state == LEN) || (state == DATA);
  assign timeout = in_load && !rx_valid && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    addr_nxt     = addr;
    byte_idx_nxt = byte_idx;
    asm_word_nxt = asm_word;
    tmo_cnt_nxt  = '0;
    run_nxt      = run_q;
    step_nxt     = 1'b0;
    rst_nxt      = 1'b0;
    err_nxt      = err_q;

    if (in_load && !rx_valid && !timeout) begin
      tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
    end

    unique case (state)
      IDLE: begin
        if (rx_valid) begin
          err_nxt = 1'b0;
          case (rx_data)
            CMD_LOAD: begin
              run_nxt   = 1'b0;
              state_nxt = LEN;
            end
            CMD_RUN:  run_nxt  = 1'b1;
            CMD_STEP: step_nxt = !run_q;
            CMD_RST: begin
              run_nxt = 1'b0;
              rst_nxt = 1'b1;
            end
            CMD_HALT: run_nxt = 1'b0;
            default:  err_nxt = 1'b1;
          endcase
        end
      end

      LEN: begin
        if (timeout) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else if (rx_valid) begin
          if (rx_data == 8'h00) begin
            state_nxt = IDLE;
          end else begin
            word_cnt_nxt = rx_data;
            addr_nxt     = '0;
            byte_idx_nxt = '0;
            state_nxt    = DATA;
          end
        end
      end

      DATA: begin
        if (timeout) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else if (rx_valid) begin
          asm_word_nxt[{byte_idx, 3'b000} +: 8] = rx_data;
          byte_idx_nxt = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            state_nxt = WRITE;
          end
        end
      end

      WRITE: begin
        if (rx_valid) begin
          err_nxt = 1'b1;
        end
        addr_nxt     = addr + ADDR_W'(1);
        word_cnt_nxt = word_cnt - 8'd1;
        byte_idx_nxt = '0;
        state_nxt    = (word_cnt == 8'd1) ? IDLE : DATA;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_we    = (state == WRITE);
    imem_addr  = addr;
    imem_wdata = asm_word;
    busy       = (state != IDLE);
    state_dbg  = state;
    cpu_run    = run_q;
    cpu_step   = step_q;
    cpu_rst    = rst_q;
    err        = err_q;
  end

endmodule

// File: tb/tb_uart_cmd_loader.sv
// Randomized bench for uart_cmd_loader: a byte-stream reference model predicts
// every output each cycle for a wide-address and a 2-bit-address instance.
module tb_uart_cmd_loader;

  localparam int unsigned T = 32;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = '0;

  logic        a_we, a_run, a_step, a_rst, a_busy, a_err;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata;
  logic [1:0]  a_state;

  logic        b_we, b_run, b_step, b_rst, b_busy, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [1:0]  b_state;

  uart_cmd_loader #(.ADDR_W(10), .WORD_W(32), .TIMEOUT_CYCLES(T)) dut_a (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .cpu_run(a_run), .cpu_step(a_step), .cpu_rst(a_rst),
    .busy(a_busy), .err(a_err), .state_dbg(a_state)
  );

  uart_cmd_loader #(.ADDR_W(2), .WORD_W(32), .TIMEOUT_CYCLES(T)) dut_b (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .cpu_run(b_run), .cpu_step(b_step), .cpu_rst(b_rst),
    .busy(b_busy), .err(b_err), .state_dbg(b_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int we_seen_a = 0;
  int we_seen_b = 0;

  always @(negedge clk) begin
    if (a_we === 1'b1) we_seen_a++;
    if (b_we === 1'b1) we_seen_b++;
  end

  // Reference model: 0 idle, 1 awaiting length, 2 collecting bytes, 3 write cycle.
  int          m_mode;
  bit          m_run, m_err, m_step, m_rst, m_we;
  int          m_words, m_nbytes, m_quiet;
  int unsigned m_addr, m_waddr;
  logic [31:0] m_word, m_wdata;
  int          writes_exp = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_err = 0; m_step = 0; m_rst = 0; m_we = 0;
    m_words = 0; m_nbytes = 0; m_quiet = 0; m_addr = 0; m_word = '0;
  endtask

  task automatic settle_write();
    m_addr++;
    m_words--;
    m_nbytes = 0;
    m_quiet  = 0;
    m_mode   = (m_words == 0) ? 0 : 2;
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_step = 0; m_rst = 0; m_we = 0;
    if (m_mode == 3) begin
      m_err = 1;
      settle_write();
    end else if (m_mode == 0) begin
      m_err = 0;
      case (b)
        8'h01: begin m_run = 0; m_mode = 1; end
        8'h02: m_run = 1;
        8'h03: m_step = !m_run;
        8'h04: begin m_run = 0; m_rst = 1; end
        8'h05: m_run = 0;
        default: m_err = 1;
      endcase
    end else if (m_mode == 1) begin
      if (b == 8'h00) m_mode = 0;
      else begin
        m_words = b; m_addr = 0; m_nbytes = 0; m_mode = 2;
      end
    end else begin
      if (m_nbytes == 0) m_word = '0;
      m_word = m_word | (32'(b) << (8 * m_nbytes));
      m_nbytes++;
      if (m_nbytes == 4) begin
        m_we = 1; m_waddr = m_addr; m_wdata = m_word;
        writes_exp++;
        m_mode = 3;
      end
    end
    m_quiet = 0;
  endtask

  task automatic model_idle();
    m_step = 0; m_rst = 0; m_we = 0;
    if (m_mode == 3) settle_write();
    else if (m_mode == 1 || m_mode == 2) begin
      m_quiet++;
      if (m_quiet == int'(T)) begin
        m_mode = 0;
        m_err  = 1;
      end
    end
  endtask

  task automatic check_all();
    check_eq("we_a", 32'(a_we), 32'(m_we));
    check_eq("we_b", 32'(b_we), 32'(m_we));
    if (m_we) begin
      check_eq("addr_a", 32'(a_addr), m_waddr % 1024);
      check_eq("addr_b", 32'(b_addr), m_waddr % 4);
      check_eq("data_a", a_wdata, m_wdata);
      check_eq("data_b", b_wdata, m_wdata);
    end
    check_eq("run_a", 32'(a_run), 32'(m_run));
    check_eq("step_a", 32'(a_step), 32'(m_step));
    check_eq("rst_a", 32'(a_rst), 32'(m_rst));
    check_eq("err_a", 32'(a_err), 32'(m_err));
    check_eq("state_a", 32'(a_state), 32'(m_mode));
    check_eq("busy_a", 32'(a_busy), 32'(m_mode != 0));
    check_eq("state_b", 32'(b_state), 32'(m_mode));
    check_eq("err_b", 32'(b_err), 32'(m_err));
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    model_byte(b);
    check_all();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      model_idle();
      check_all();
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned gap);
    for (int k = 0; k < 4; k++) begin
      send(w[8*k +: 8]);
      idle(gap);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_all();
    check_eq("rst_addr_a", 32'(a_addr), 32'd0);
    check_eq("rst_wdata_a", a_wdata, 32'd0);
  endtask

  task automatic check_writes();
    check_eq("writes_a", 32'(we_seen_a), 32'(writes_exp));
    check_eq("writes_b", 32'(we_seen_b), 32'(writes_exp));
  endtask

  initial begin
    model_reset();
    do_reset();

    send(8'h02); idle(2); send(8'h03); idle(2);
    send(8'h05); idle(1); send(8'h03); idle(1); send(8'h03); idle(2);

    send(8'h01); idle(1); send(8'h02); idle(1);
    send_word(32'h12345678, 2);
    send_word(32'hDEADBEEF, 2);
    idle(2);
    check_writes();

    send(8'h01); idle(1); send(8'h01); idle(1);
    send(8'hAA); idle(1); send(8'hBB); idle(T + 5);
    send(8'h02); idle(2);
    check_writes();

    send(8'h7F); idle(1); send(8'h01); idle(1); send(8'h00); idle(2);

    // Five words through a 4-entry address space on dut_b.
    send(8'h01); idle(1); send(8'h05); idle(1);
    for (int i = 0; i < 5; i++) send_word($urandom, 1);
    idle(2);
    check_writes();

    // Gap of T-1 idle cycles keeps the load alive; T cycles of silence ends it.
    send(8'h01); idle(1); send(8'h01); idle(1);
    send(8'h11); idle(T - 1); send(8'h22); idle(T - 1);
    send(8'h33); idle(1); send(8'h44); idle(2);
    send(8'h01); idle(T); idle(2);
    check_writes();

    // Byte arriving during the write cycle is dropped.
    send(8'h01); idle(1); send(8'h02); idle(1);
    send(8'hA1); idle(1); send(8'hA2); idle(1); send(8'hA3); idle(1); send(8'hA4);
    send(8'h99); idle(1);
    send_word(32'hCAFEF00D, 1);
    idle(2);
    check_writes();

    // Reset mid-load: only the first word lands.
    send(8'h02); idle(1);
    send(8'h01); idle(1); send(8'h02); idle(1);
    send_word(32'h0BADC0DE, 1);
    send(8'h5A); idle(1); send(8'hA5); idle(1);
    do_reset();
    idle(3);
    check_writes();

    for (int i = 0; i < 600; i++) begin
      logic [7:0] b;
      if (m_mode == 1) b = 8'($urandom_range(0, 6));
      else if (m_mode == 0) b = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(1, 5));
      else b = 8'($urandom);
      send(b);
      if ($urandom_range(0, 59) == 0) idle(T + 4);
      else idle($urandom_range(0, 3));
    end
    idle(T + 5);
    check_writes();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
